// File: rtl/ast_rr_arbiter.sv
// ast_rr_arbiter: packet-locked round-robin arbiter in front of the width converter.
// One output register stage; data, empty and channel pass through unchanged.
module ast_rr_arbiter #(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = 64,
    parameter int EMPTY_W   = 3,
    parameter int CHANNEL_W = 10,
    localparam int SRC_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic [N_SRC*DATA_W-1:0]    ast_data_i,
    input  logic [N_SRC-1:0]           ast_startofpacket_i,
    input  logic [N_SRC-1:0]           ast_endofpacket_i,
    input  logic [N_SRC-1:0]           ast_valid_i,
    input  logic [N_SRC*EMPTY_W-1:0]   ast_empty_i,
    input  logic [N_SRC*CHANNEL_W-1:0] ast_channel_i,
    output logic [N_SRC-1:0]           ast_ready_o,
    output logic [DATA_W-1:0]          ast_data_o,
    output logic                       ast_startofpacket_o,
    output logic                       ast_endofpacket_o,
    output logic                       ast_valid_o,
    output logic [EMPTY_W-1:0]         ast_empty_o,
    output logic [CHANNEL_W-1:0]       ast_channel_o,
    input  logic                       ast_ready_i,
    output logic [SRC_W-1:0]           grant_o,
    output logic                       pkt_err_o
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state;
    logic [SRC_W-1:0]       g;
    logic [SRC_W-1:0]       rr_ptr;
    logic [SRC_W-1:0]       pick;
    logic [SRC_W-1:0]       next_ptr;
    logic                   found;
    logic                   first_beat;
    logic                   out_valid;
    logic                   g_ready;
    logic                   xfer;
    logic [DATA_W-1:0]      sel_data;
    logic                   sel_sop;
    logic                   sel_eop;
    logic [EMPTY_W-1:0]     sel_empty;
    logic [CHANNEL_W-1:0]   sel_channel;

    assign grant_o     = g;
    assign ast_valid_o = out_valid;

    assign sel_data    = ast_data_i[int'(g)*DATA_W +: DATA_W];
    assign sel_sop     = ast_startofpacket_i[g];
    assign sel_eop     = ast_endofpacket_i[g];
    assign sel_empty   = ast_empty_i[int'(g)*EMPTY_W +: EMPTY_W];
    assign sel_channel = ast_channel_i[int'(g)*CHANNEL_W +: CHANNEL_W];

    // Ready depends only on state and downstream ready, never on valid.
    assign g_ready = (state == LOCKED) && (!out_valid || ast_ready_i);
    assign xfer    = g_ready && ast_valid_i[g];

    assign next_ptr = (g == SRC_W'(N_SRC - 1)) ? '0 : g + 1'b1;

    always_comb begin
        ast_ready_o    = '0;
        ast_ready_o[g] = g_ready;
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!found && ast_valid_i[(int'(rr_ptr) + i) % N_SRC]) begin
                found = 1'b1;
                pick  = SRC_W'((int'(rr_ptr) + i) % N_SRC);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state               <= IDLE;
            g                   <= '0;
            rr_ptr              <= '0;
            first_beat          <= 1'b0;
            out_valid           <= 1'b0;
            ast_data_o          <= '0;
            ast_startofpacket_o <= 1'b0;
            ast_endofpacket_o   <= 1'b0;
            ast_empty_o         <= '0;
            ast_channel_o       <= '0;
            pkt_err_o           <= 1'b0;
        end else begin
            pkt_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        g          <= pick;
                        first_beat <= 1'b1;
                        state      <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        first_beat <= 1'b0;
                        // Missing SOP on the first beat or a stray SOP later.
                        pkt_err_o  <= first_beat ? !sel_sop : sel_sop;
                        if (sel_eop) begin
                            state  <= IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
            endcase
            if (xfer) begin
                out_valid           <= 1'b1;
                ast_data_o          <= sel_data;
                ast_startofpacket_o <= sel_sop;
                ast_endofpacket_o   <= sel_eop;
                ast_empty_o         <= sel_empty;
                ast_channel_o       <= sel_channel;
            end else if (ast_ready_i) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ast_rr_arbiter.sv
// tb_ast_rr_arbiter: directed bench for the packet round-robin arbiter.
// Source queues feed the DUT; accepted output beats are logged and checked.
module tb_ast_rr_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [9:0]  ch;
    } beat_t;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic [9:0]  ch;
        logic [1:0]  gnt;
        logic        err;
        int          cyc;
    } obs_t;

    logic          clk = 1'b0;
    logic          srst_i;
    logic [255:0]  ast_data_i;
    logic [3:0]    ast_startofpacket_i;
    logic [3:0]    ast_endofpacket_i;
    logic [3:0]    ast_valid_i;
    logic [11:0]   ast_empty_i;
    logic [39:0]   ast_channel_i;
    logic [3:0]    ast_ready_o;
    logic [63:0]   ast_data_o;
    logic          ast_startofpacket_o;
    logic          ast_endofpacket_o;
    logic          ast_valid_o;
    logic [2:0]    ast_empty_o;
    logic [9:0]    ast_channel_o;
    logic          ast_ready_i;
    logic [1:0]    grant_o;
    logic          pkt_err_o;

    beat_t srcq[N][$];
    obs_t  log_q[$];
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;

    ast_rr_arbiter dut (
        .clk_i               (clk),
        .srst_i              (srst_i),
        .ast_data_i          (ast_data_i),
        .ast_startofpacket_i (ast_startofpacket_i),
        .ast_endofpacket_i   (ast_endofpacket_i),
        .ast_valid_i         (ast_valid_i),
        .ast_empty_i         (ast_empty_i),
        .ast_channel_i       (ast_channel_i),
        .ast_ready_o         (ast_ready_o),
        .ast_data_o          (ast_data_o),
        .ast_startofpacket_o (ast_startofpacket_o),
        .ast_endofpacket_o   (ast_endofpacket_o),
        .ast_valid_o         (ast_valid_o),
        .ast_empty_o         (ast_empty_o),
        .ast_channel_o       (ast_channel_o),
        .ast_ready_i         (ast_ready_i),
        .grant_o             (grant_o),
        .pkt_err_o           (pkt_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (srcq[k].size() > 0) begin
                ast_valid_i[k]          = 1'b1;
                ast_data_i[k*64 +: 64]  = srcq[k][0].data;
                ast_startofpacket_i[k]  = srcq[k][0].sop;
                ast_endofpacket_i[k]    = srcq[k][0].eop;
                ast_empty_i[k*3 +: 3]   = srcq[k][0].empty;
                ast_channel_i[k*10 +: 10] = srcq[k][0].ch;
            end else begin
                ast_valid_i[k]          = 1'b0;
                ast_data_i[k*64 +: 64]  = '0;
                ast_startofpacket_i[k]  = 1'b0;
                ast_endofpacket_i[k]    = 1'b0;
                ast_empty_i[k*3 +: 3]   = '0;
                ast_channel_i[k*10 +: 10] = '0;
            end
        end
    endtask

    task automatic push(input int k, input logic [63:0] d, input logic sop,
                        input logic eop, input logic [2:0] e,
                        input logic [9:0] ch);
        beat_t b;
        b.data  = d;
        b.sop   = sop;
        b.eop   = eop;
        b.empty = e;
        b.ch    = ch;
        srcq[k].push_back(b);
        drive();
    endtask

    task automatic flush();
        for (int k = 0; k < N; k++) srcq[k].delete();
        log_q.delete();
        drive();
    endtask

    task automatic do_reset();
        srst_i = 1'b1;
        @(negedge clk);
        srst_i = 1'b0;
        flush();
    endtask

    function automatic logic busy();
        logic b;
        b = ast_valid_o;
        for (int k = 0; k < N; k++) if (srcq[k].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (busy() && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(busy()), 64'(0));
        @(negedge clk);
    endtask

    task automatic wait_data(input string tag, input logic [63:0] d);
        int n;
        n = 0;
        while (!(ast_valid_o && ast_data_o == d) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, ast_data_o, d);
    endtask

    always @(negedge clk) drive();

    always @(posedge clk) begin
        obs_t o;
        if (!srst_i) begin
            for (int k = 0; k < N; k++)
                if (ast_valid_i[k] && ast_ready_o[k] && srcq[k].size() > 0)
                    void'(srcq[k].pop_front());
            if (ast_valid_o && ast_ready_i) begin
                o.data  = ast_data_o;
                o.sop   = ast_startofpacket_o;
                o.eop   = ast_endofpacket_o;
                o.empty = ast_empty_o;
                o.ch    = ast_channel_o;
                o.gnt   = grant_o;
                o.err   = pkt_err_o;
                o.cyc   = cyc;
                log_q.push_back(o);
            end
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        srst_i      = 1'b1;
        ast_ready_i = 1'b1;
        drive();
        @(negedge clk);
        @(negedge clk);
        srst_i = 1'b0;

        // reset state
        chk("rst_valid", 64'(ast_valid_o), 64'(0));
        chk("rst_sop", 64'(ast_startofpacket_o), 64'(0));
        chk("rst_eop", 64'(ast_endofpacket_o), 64'(0));
        chk("rst_data", ast_data_o, 64'(0));
        chk("rst_empty", 64'(ast_empty_o), 64'(0));
        chk("rst_chan", 64'(ast_channel_o), 64'(0));
        chk("rst_ready", 64'(ast_ready_o), 64'(0));
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_err", 64'(pkt_err_o), 64'(0));

        // single source 2, 3-beat packet
        t0 = cyc;
        push(2, 64'hA, 1'b1, 1'b0, 3'd0, 10'h15);
        push(2, 64'hB, 1'b0, 1'b0, 3'd0, 10'h15);
        push(2, 64'hC, 1'b0, 1'b1, 3'd5, 10'h15);
        @(negedge clk);
        chk("t1_ready", 64'(ast_ready_o), 64'(4'b0100));
        chk("t1_grant", 64'(grant_o), 64'(2));
        drain("t1_drain");
        chk("t1_count", 64'(log_q.size()), 64'(3));
        if (log_q.size() == 3) begin
            chk("t1_latency", 64'(log_q[0].cyc - t0), 64'(2));
            chk("t1_d0", log_q[0].data, 64'hA);
            chk("t1_d1", log_q[1].data, 64'hB);
            chk("t1_d2", log_q[2].data, 64'hC);
            chk("t1_sop", 64'({log_q[0].sop, log_q[1].sop, log_q[2].sop}),
                64'(3'b100));
            chk("t1_eop", 64'({log_q[0].eop, log_q[1].eop, log_q[2].eop}),
                64'(3'b001));
            chk("t1_empty", 64'(log_q[2].empty), 64'(5));
            for (int i = 0; i < 3; i++) begin
                chk("t1_chan", 64'(log_q[i].ch), 64'(10'h15));
                chk("t1_gnt", 64'(log_q[i].gnt), 64'(2));
                chk("t1_err", 64'(log_q[i].err), 64'(0));
            end
        end

        // all four sources, two 2-beat packets each
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < N; k++)
                for (int b = 0; b < 2; b++)
                    push(k, 64'(k * 256 + p * 16 + b), b == 0, b == 1, 3'd0,
                         10'(k));
        drain("t2_drain");
        chk("t2_count", 64'(log_q.size()), 64'(16));
        if (log_q.size() == 16) begin
            for (int j = 0; j < 16; j++) begin
                chk("t2_data", log_q[j].data,
                    64'(((j / 2) % 4) * 256 + (j / 8) * 16 + (j % 2)));
                chk("t2_gnt", 64'(log_q[j].gnt), 64'((j / 2) % 4));
                if (j > 0)
                    chk("t2_gap", 64'(log_q[j].cyc - log_q[j-1].cyc),
                        64'((j % 2 == 1) ? 1 : 2));
            end
        end

        // source 0 and 3 arrive while source 1 is mid-packet
        do_reset();
        for (int b = 0; b < 4; b++)
            push(1, 64'(16 + b), b == 0, b == 3, 3'd0, 10'd1);
        @(negedge clk);
        @(negedge clk);
        push(0, 64'h00, 1'b1, 1'b0, 3'd0, 10'd0);
        push(0, 64'h01, 1'b0, 1'b1, 3'd0, 10'd0);
        push(3, 64'h30, 1'b1, 1'b0, 3'd0, 10'd3);
        push(3, 64'h31, 1'b0, 1'b1, 3'd0, 10'd3);
        drain("t3_drain");
        chk("t3_count", 64'(log_q.size()), 64'(8));
        if (log_q.size() == 8) begin
            chk("t3_d0", log_q[0].data, 64'h10);
            chk("t3_d3", log_q[3].data, 64'h13);
            chk("t3_d4", log_q[4].data, 64'h30);
            chk("t3_d5", log_q[5].data, 64'h31);
            chk("t3_d6", log_q[6].data, 64'h00);
            chk("t3_d7", log_q[7].data, 64'h01);
            chk("t3_gnt", 64'({log_q[0].gnt, log_q[3].gnt, log_q[4].gnt,
                               log_q[6].gnt}), 64'(8'b01_01_11_00));
        end

        // backpressure mid-packet from source 2
        log_q.delete();
        for (int b = 0; b < 4; b++)
            push(2, 64'(80 + b), b == 0, b == 3, 3'd0, 10'd2);
        wait_data("t4_reach", 64'h51);
        ast_ready_i = 1'b0;
        #1;
        chk("t4_rdy0", 64'(ast_ready_o), 64'(0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold", 64'({ast_valid_o, ast_startofpacket_o,
                                ast_endofpacket_o, ast_data_o[7:0]}),
                64'({3'b100, 8'h51}));
            chk("t4_rdy", 64'(ast_ready_o), 64'(0));
        end
        ast_ready_i = 1'b1;
        drain("t4_drain");
        chk("t4_count", 64'(log_q.size()), 64'(4));
        if (log_q.size() == 4)
            for (int i = 0; i < 4; i++)
                chk("t4_data", log_q[i].data, 64'(80 + i));

        // framing errors: missing SOP, then stray SOP
        log_q.delete();
        push(2, 64'h60, 1'b0, 1'b0, 3'd0, 10'd2);
        push(2, 64'h61, 1'b1, 1'b0, 3'd0, 10'd2);
        push(2, 64'h62, 1'b0, 1'b1, 3'd0, 10'd2);
        drain("t5_drain");
        chk("t5_count", 64'(log_q.size()), 64'(3));
        if (log_q.size() == 3) begin
            chk("t5_err", 64'({log_q[0].err, log_q[1].err, log_q[2].err}),
                64'(3'b110));
            chk("t5_sop", 64'({log_q[0].sop, log_q[1].sop, log_q[2].sop}),
                64'(3'b010));
            chk("t5_d1", log_q[1].data, 64'h61);
            chk("t5_d2", log_q[2].data, 64'h62);
        end

        // reset on beat 2 of a 4-beat packet from source 3
        log_q.delete();
        for (int b = 0; b < 4; b++)
            push(3, 64'(112 + b), b == 0, b == 3, 3'd0, 10'd3);
        wait_data("t6_reach", 64'h71);
        srst_i = 1'b1;
        @(negedge clk);
        chk("t6_valid", 64'(ast_valid_o), 64'(0));
        chk("t6_ready", 64'(ast_ready_o), 64'(0));
        chk("t6_grant", 64'(grant_o), 64'(0));
        srst_i = 1'b0;
        flush();
        push(1, 64'h80, 1'b1, 1'b1, 3'd0, 10'd1);
        push(3, 64'h90, 1'b1, 1'b1, 3'd0, 10'd3);
        drain("t6_drain");
        chk("t6_count", 64'(log_q.size()), 64'(2));
        if (log_q.size() == 2) begin
            chk("t6_first", log_q[0].data, 64'h80);
            chk("t6_gnt0", 64'(log_q[0].gnt), 64'(1));
            chk("t6_second", log_q[1].data, 64'h90);
            chk("t6_gnt1", 64'(log_q[1].gnt), 64'(3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ast_rr_arbiter.md
# ast_rr_arbiter

Round-robin packet arbiter that shares the single Avalon-ST input of the width converter between `N_SRC` upstream requesters. Grants are held for a whole packet, from startofpacket to endofpacket, so packets are never interleaved. Beats pass through one output register stage. The block sits directly in front of the converter sink port and forwards data, empty and channel unchanged.

## Interface
- `N_SRC`, 4: number of requesters, ≥2.
- `DATA_W`, 64: beat width; equals the converter's input data width.
- `EMPTY_W`, 3: empty field width, `$clog2(DATA_W/8)`, minimum 1.
- `CHANNEL_W`, 10: channel width.
- `SRC_W`, derived: `$clog2(N_SRC)`, minimum 1.

Ports:
- `clk_i`  in  1  single clock; all logic is rising-edge.
- `srst_i`  in  1  synchronous reset, active-high.
- `ast_data_i`  in  N_SRC*DATA_W  per-source data; source k occupies slice [k*DATA_W +: DATA_W].
- `ast_startofpacket_i`  in  N_SRC  per-source SOP.
- `ast_endofpacket_i`  in  N_SRC  per-source EOP.
- `ast_valid_i`  in  N_SRC  per-source valid.
- `ast_empty_i`  in  N_SRC*EMPTY_W  per-source empty; only meaningful on EOP beats.
- `ast_channel_i`  in  N_SRC*CHANNEL_W  per-source channel.
- `ast_ready_o`  out  N_SRC  per-source ready.
- `ast_data_o`  out  DATA_W  output data to the converter.
- `ast_startofpacket_o`  out  1  output SOP.
- `ast_endofpacket_o`  out  1  output EOP.
- `ast_valid_o`  out  1  output valid.
- `ast_empty_o`  out  EMPTY_W  output empty.
- `ast_channel_o`  out  CHANNEL_W  output channel.
- `ast_ready_i`  in  1  ready from the converter.
- `grant_o`  out  SRC_W  index of the current or last granted source.
- `pkt_err_o`  out  1  one-cycle pulse on a framing error from the granted source.

## Operation
- FSM states:
  - **IDLE**: no grant held. All `ast_ready_o` are 0.
  - **LOCKED**: grant held by source `g`. Only `ast_ready_o[g]` may be 1.
- Round-robin pointer `rr_ptr` (SRC_W bits):
  - In IDLE, the request vector is `ast_valid_i`.
  - Search order is `rr_ptr`, `rr_ptr+1`, … wrapping modulo `N_SRC`. The first valid source wins.
  - A win registers `g`, drives `grant_o <= g` and moves the FSM to LOCKED.
  - With no valid source, the FSM stays in IDLE.
- Ready: in LOCKED, `ast_ready_o[g] = !out_valid || ast_ready_i`. Every other bit is 0.
- Beat transfer:
  - A beat transfers when `ast_valid_i[g] && ast_ready_o[g]`.
  - On transfer, the output register captures data, SOP, EOP, empty and channel of source `g` and sets `out_valid`.
  - If there is no transfer and `ast_ready_i` is 1, `out_valid` clears.
- Release: a transferred beat with EOP moves the FSM to IDLE and sets `rr_ptr <= (g+1) mod N_SRC`, with wrap from `N_SRC-1` to 0.
- Single-beat packets (SOP and EOP on the same beat) grant and release normally.
- Framing checks, evaluated on transferred beats of source `g`:
  - The first beat after a grant has SOP = 0, or
  - a later beat of the same packet has SOP = 1.
  - Either case pulses `pkt_err_o` for one cycle. The beat is still forwarded unchanged and the grant is unaffected.
- Backpressure: when `ast_ready_i` is 0 with `out_valid` = 1, the output register holds all fields stable and `ast_ready_o[g]` is 0.
- Reset mid-packet:
  - Next state is IDLE, `rr_ptr` = 0, `out_valid` = 0.
  - The truncated packet gets no EOP. The downstream converter is reset by the same `srst_i`.

## Timing
- Reset values:
  - `ast_valid_o` = 0, `ast_startofpacket_o` = 0, `ast_endofpacket_o` = 0.
  - `ast_data_o` = 0, `ast_empty_o` = 0, `ast_channel_o` = 0.
  - `ast_ready_o` = 0, `grant_o` = 0, `pkt_err_o` = 0.
- Arbitration: one cycle (IDLE to LOCKED). The first `ast_ready_o[g]` is asserted in the cycle after the request is seen.
- Data latency: one cycle from input transfer to `ast_valid_o`.
- Throughput:
  - One beat per cycle inside a packet while `ast_ready_i` = 1.
  - Exactly one bubble (the IDLE cycle) between consecutive packets.
- `ast_ready_o` is combinational from `ast_ready_i` and registered state. There is no combinational path from any `ast_valid_i` to `ast_ready_o`.
- `pkt_err_o` is registered and asserts in the same cycle the offending beat appears on the output.

## Test plan
- Single source 2 holds valid for a 3-beat packet with data 0xA, 0xB, 0xC, channel 0x15, and empty 5 on the EOP beat → output shows the same 3 beats with SOP on beat 1, EOP on beat 3, empty 5, channel 0x15. `grant_o` = 2. Output begins 2 cycles after the first valid.
- All 4 sources request continuously with 2-beat packets after reset → grant order is 0,1,2,3,0, with one idle cycle between packets and no interleaving of beats.
- Source 1 is mid-packet while source 0 raises valid → source 0 waits until source 1's EOP transfers. The next grant is source 2 if it is valid, otherwise 3, otherwise 0.
- Grant held with `ast_ready_i` low for 5 cycles mid-packet → output fields stay stable, `ast_ready_o` is 0000, and no beats are lost or duplicated after release.
- Granted source sends a first beat without SOP, then a second beat with SOP → `pkt_err_o` pulses on each beat, and both beats are forwarded.
- `srst_i` is pulsed on beat 2 of a 4-beat packet from source 3 → the cycle after reset, `ast_valid_o` = 0, `rr_ptr` = 0, and the next grant goes to the lowest valid index starting from 0.
